// File: rtl/cpu_program_loader.sv
// Loads a 16-byte image buffer into a CPU over a ready/consume handshake.
// Optional handshake watchdog enabled by defining LOADER_TIMEOUT_EN.
module cpu_program_loader #(
  parameter int NUM_BYTES      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       cpu_ready,
  input  logic       cpu_done,
  output logic [7:0] prog_data,
  output logic       programming,
  output logic       busy,
  output logic       loaded,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    ACK       = 3'd2,
    WAIT_DONE = 3'd3,
    FINISH    = 3'd4,
    ERROR     = 3'd5
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

  state_t     state, state_nxt;
  logic [3:0] index, index_nxt;
  logic [7:0] buffer [16];
  logic       wr_ok;
  logic       wd_expired;
  logic [7:0] byte_nxt;

  assign wr_ok = wr_en && !busy;

`ifdef LOADER_TIMEOUT_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wd_cnt;

  // Counter restarts on every state change, so it measures time in one state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wd_cnt <= 8'd0;
    else if (state_nxt != state) wd_cnt <= 8'd0;
    else if (busy)               wd_cnt <= wd_cnt + 8'd1;
  end

  assign wd_expired = busy && (wd_cnt == WD_LIMIT);
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      index <= 4'd0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    index_nxt = index;
    case (state)
      IDLE, FINISH, ERROR: begin
        if (start) begin
          state_nxt = SEND;
          index_nxt = 4'd0;
        end
      end
      SEND: begin
        if (cpu_done)       state_nxt = ERROR;
        else if (cpu_ready) state_nxt = ACK;
        else if (wd_expired) state_nxt = ERROR;
      end
      ACK: begin
        if (cpu_done) begin
          state_nxt = ERROR;
        end else if (!cpu_ready) begin
          if (index == LAST_IDX) begin
            state_nxt = WAIT_DONE;
          end else begin
            index_nxt = index + 4'd1;
            state_nxt = SEND;
          end
        end else if (wd_expired) begin
          state_nxt = ERROR;
        end
      end
      WAIT_DONE: begin
        if (cpu_done)        state_nxt = FINISH;
        else if (wd_expired) state_nxt = ERROR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == SEND) || (state == ACK) || (state == WAIT_DONE);
    programming = busy;
    loaded      = (state == FINISH);
    error       = (state == ERROR);
  end

  // Bypass lets a write landing on the start edge reach the first byte.
  assign byte_nxt = (wr_ok && (wr_addr == index_nxt)) ? wr_data : buffer[index_nxt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) buffer[i] <= 8'd0;
    end else if (wr_ok) begin
      buffer[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prog_data <= 8'd0;
    else if ((state_nxt == SEND) || (state_nxt == ACK))
      prog_data <= byte_nxt;
    else
      prog_data <= 8'd0;
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Bench for cpu_program_loader: a 16-byte and a 4-byte instance share stimulus via sel.
module tb_cpu_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, wr_en, start, cpu_ready, cpu_done, sel;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  logic [7:0] pd_a, pd_b;
  logic       prg_a, prg_b, bsy_a, bsy_b, ld_a, ld_b, er_a, er_b;

  logic [7:0] prog_data;
  logic       programming, busy, loaded, error;

  cpu_program_loader #(.NUM_BYTES(16), .TIMEOUT_CYCLES(20)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en & ~sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start & ~sel), .cpu_ready(cpu_ready & ~sel), .cpu_done(cpu_done & ~sel),
    .prog_data(pd_a), .programming(prg_a), .busy(bsy_a), .loaded(ld_a), .error(er_a)
  );

  cpu_program_loader #(.NUM_BYTES(4), .TIMEOUT_CYCLES(20)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en & sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start & sel), .cpu_ready(cpu_ready & sel), .cpu_done(cpu_done & sel),
    .prog_data(pd_b), .programming(prg_b), .busy(bsy_b), .loaded(ld_b), .error(er_b)
  );

  assign prog_data   = sel ? pd_b  : pd_a;
  assign programming = sel ? prg_b : prg_a;
  assign busy        = sel ? bsy_b : bsy_a;
  assign loaded      = sel ? ld_b  : ld_a;
  assign error       = sel ? er_b  : er_a;

  // Transaction-level model: image contents plus load status and current byte.
  logic [7:0] model_buf [2][16];
  logic       m_prog, m_loaded, m_error, m_vld;
  int         m_idx;
  logic       chk_en;
  int         n_checks = 0;
  int         n_err    = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check8("prog_data", prog_data, m_vld ? model_buf[sel][m_idx] : 8'h00);
      check1("programming", programming, m_prog);
      check1("busy", busy, m_prog);
      check1("loaded", loaded, m_loaded);
      check1("error", error, m_error);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_model_status(input logic prog, input logic ld, input logic er);
    m_prog = prog; m_loaded = ld; m_error = er; m_vld = prog; m_idx = 0;
  endtask

  task automatic write_byte(input logic [3:0] a, input logic [7:0] d);
    logic was_busy;
    was_busy = m_prog;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (!was_busy) model_buf[sel][a] = d;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    set_model_status(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_start_wr(input logic [3:0] a, input logic [7:0] d);
    start = 1'b1; wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    start = 1'b0; wr_en = 1'b0;
    model_buf[sel][a] = d;
    set_model_status(1'b1, 1'b0, 1'b0);
  endtask

  task automatic cpu_byte(output logic [7:0] got);
    int nb;
    nb = sel ? 4 : 16;
    cpu_ready = 1'b1;
    tick();
    got = prog_data;
    cpu_ready = 1'b0;
    tick();
    if (m_idx == nb - 1) m_vld = 1'b0;
    else m_idx++;
  endtask

  task automatic cpu_finish();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    set_model_status(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx [16];
    logic [7:0] got;
    int hs;

    chk_en = 1'b0;
    rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; cpu_ready = 1'b0; cpu_done = 1'b0;
    sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
    for (int i = 0; i < 16; i++) begin model_buf[0][i] = 8'h00; model_buf[1][i] = 8'h00; end
    set_model_status(1'b0, 1'b0, 1'b0);
    #1;
    check8("reset_prog_data", pd_a, 8'h00);
    check1("reset_programming", prg_a, 1'b0);
    check1("reset_busy", bsy_a, 1'b0);
    check1("reset_loaded", ld_a, 1'b0);
    check1("reset_error", er_a, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Full 16-byte load of 0x10..0x1F
    for (int i = 0; i < 16; i++) write_byte(4'(i), 8'(8'h10 + i));
    do_start();
    for (int i = 0; i < 16; i++) begin cpu_byte(got); rx[i] = got; end
    for (int i = 0; i < 16; i++) check8("full_load_byte", rx[i], 8'(8'h10 + i));
    repeat (3) tick();
    check1("wait_done_programming", programming, 1'b1);
    cpu_finish();
    check1("full_load_loaded", loaded, 1'b1);
    check1("full_load_programming", programming, 1'b0);

    // Write while busy is dropped
    do_start();
    write_byte(4'd3, 8'hAA);
    for (int i = 0; i < 16; i++) begin cpu_byte(got); rx[i] = got; end
    check8("busy_write_byte3", rx[3], 8'h13);
    check8("busy_write_byte4", rx[4], 8'h14);
    cpu_finish();

    // cpu_done during byte 5 ACK aborts
    do_start();
    for (int i = 0; i < 5; i++) cpu_byte(got);
    cpu_ready = 1'b1;
    tick();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0; cpu_ready = 1'b0;
    set_model_status(1'b0, 1'b0, 1'b1);
    check1("abort_error", error, 1'b1);
    check1("abort_programming", programming, 1'b0);
    check1("abort_loaded", loaded, 1'b0);

    // Reset during byte 7
    do_start();
    for (int i = 0; i < 7; i++) cpu_byte(got);
    cpu_ready = 1'b1;
    tick();
    check8("byte7_before_reset", prog_data, 8'h17);
    #2;
    rst_n = 1'b0;
    #1;
    check8("midreset_prog_data", pd_a, 8'h00);
    check1("midreset_programming", prg_a, 1'b0);
    check1("midreset_busy", bsy_a, 1'b0);
    check1("midreset_loaded", ld_a, 1'b0);
    check1("midreset_error", er_a, 1'b0);
    cpu_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin model_buf[0][i] = 8'h00; model_buf[1][i] = 8'h00; end
    set_model_status(1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check1("post_reset_idle", programming, 1'b0);
    do_start();
    for (int i = 0; i < 16; i++) begin cpu_byte(got); rx[i] = got; end
    for (int i = 0; i < 16; i++) check8("post_reset_byte", rx[i], 8'h00);
    cpu_finish();

    // 4-byte instance: same-cycle write and start
    sel = 1'b1;
    set_model_status(1'b0, 1'b0, 1'b0);
    write_byte(4'd1, 8'h41);
    write_byte(4'd2, 8'h42);
    write_byte(4'd3, 8'h43);
    write_byte(4'd4, 8'h99);
    do_start_wr(4'd0, 8'h5C);
    hs = 0;
    for (int i = 0; i < 4; i++) begin cpu_byte(got); rx[i] = got; hs++; end
    check8("nb4_first_byte", rx[0], 8'h5C);
    check8("nb4_byte1", rx[1], 8'h41);
    check8("nb4_byte3", rx[3], 8'h43);
    check8("nb4_handshakes", 8'(hs), 8'd4);
    check1("nb4_wait_done_programming", programming, 1'b1);
    check8("nb4_wait_done_data", prog_data, 8'h00);
    cpu_ready = 1'b1;
    tick();
    cpu_ready = 1'b0;
    tick();
    cpu_finish();
    check1("nb4_loaded", loaded, 1'b1);

    // Stalled handshake
    sel = 1'b0;
    set_model_status(1'b0, 1'b1, 1'b0);
    do_start();
`ifdef LOADER_TIMEOUT_EN
    repeat (19) tick();
    check1("timeout_not_yet", busy, 1'b1);
    tick();
    set_model_status(1'b0, 1'b0, 1'b1);
    check1("timeout_error", error, 1'b1);
`else
    repeat (1000) tick();
    check1("no_timeout_busy", busy, 1'b1);
    check1("no_timeout_error", error, 1'b0);
`endif
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_program_loader.md
CPU_PROGRAM_LOADER -- requirements
Module: cpu_program_loader

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 16: number of bytes sent per load (1..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: handshake watchdog limit (8-bit).
REQ-003 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en, input, 1, image buffer write strobe.
REQ-006 SHALL have port wr_addr, input, 4, image buffer write address.
REQ-007 SHALL have port wr_data, input, 8, image buffer write data.
REQ-008 SHALL have port start, input, 1, begin a load (level sampled each cycle).
REQ-009 SHALL have port cpu_ready, input, 1, CPU requests/samples the next byte.
REQ-010 SHALL have port cpu_done, input, 1, CPU reports load complete.
REQ-011 SHALL have port prog_data, output, 8, byte presented to the CPU ui_in.
REQ-012 SHALL have port programming, output, 1, drives the CPU programming input.
REQ-013 SHALL have port busy, output, 1, high in any state except IDLE, FINISH and ERROR.
REQ-014 SHALL have port loaded, output, 1, last load completed.
REQ-015 SHALL have port error, output, 1, last load aborted.

Function
REQ-016 SHALL hold a 16x8 image buffer; wr_en writes wr_data to wr_addr at the clock edge unless busy=1, in which case the write is dropped.
REQ-017 SHALL implement states IDLE, SEND, ACK, WAIT_DONE, FINISH, ERROR.
REQ-018 SHALL accept start only in IDLE, FINISH or ERROR: edge N moves to SEND, clears loaded/error and byte index; programming=1 from cycle N+1.
REQ-019 SHALL apply a same-cycle wr_en and accepted start both, with the written byte included in the transfer.
REQ-020 SHALL, in SEND and ACK, drive prog_data = buffer[index] registered; prog_data=0 in all other states.
REQ-021 SHALL in SEND wait for cpu_ready=1, then go to ACK.
REQ-022 SHALL in ACK wait for cpu_ready=0 (byte consumed); then if index=NUM_BYTES-1 go to WAIT_DONE, else increment index and return to SEND.
REQ-023 SHALL in WAIT_DONE keep programming=1 until cpu_done=1, then go to FINISH.
REQ-024 SHALL in FINISH drive programming=0, loaded=1, held until next accepted start.
REQ-025 SHALL treat cpu_done=1 in SEND or ACK as protocol violation: go to ERROR.
REQ-026 SHALL in ERROR drive programming=0, error=1, held until next accepted start.
REQ-027 SHALL keep index 4-bit with no wrap beyond NUM_BYTES-1.

Reset
REQ-028 SHALL on rst_n=0 immediately force IDLE, index=0, buffer=0, prog_data=0, programming=0, loaded=0, error=0, busy=0, independent of clk.
REQ-029 SHALL, on reset mid-load, drop programming at once and require a new start after release.

Configuration
REQ-030 SHALL, with macro LOADER_TIMEOUT_EN defined, count cycles spent in SEND, ACK or WAIT_DONE since last state change; reaching TIMEOUT_CYCLES goes to ERROR.
REQ-031 SHALL, without LOADER_TIMEOUT_EN, contain no watchdog counter and wait indefinitely in SEND, ACK and WAIT_DONE.

Verification
REQ-032 SHALL verify: buffer 0x10..0x1F, start, CPU model pulses cpu_ready per byte then cpu_done -> CPU receives 0x10..0x1F in order, loaded=1, programming=0.
REQ-033 SHALL verify: wr_en addr 3 data 0xAA while busy -> byte 3 still sent as original value.
REQ-034 SHALL verify: cpu_done=1 during byte 5 ACK -> error=1, programming=0, loaded=0.
REQ-035 SHALL verify: rst_n=0 during byte 7 -> all outputs 0 same cycle; buffer reads 0 on next load.
REQ-036 SHALL verify (LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=20): cpu_ready held 0 -> error=1 after 20 cycles in SEND; without macro still SEND after 1000 cycles.
REQ-037 SHALL verify: NUM_BYTES=4, start+wr_en addr 0 data 0x5C same cycle -> first byte 0x5C, exactly 4 handshakes before WAIT_DONE.
